// File: rtl/register_file.sv
// 8-entry register file for the single-cycle MCU datapath: two combinational read
// ports (A-bus, B-mux), one synchronous write port from bus_D, plus write statistics.
module register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter bit BYPASS     = 1'b0,
  parameter bit ZERO_R0    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RW,
  input  logic [ADDR_WIDTH-1:0] DA,
  input  logic [ADDR_WIDTH-1:0] AA,
  input  logic [ADDR_WIDTH-1:0] BA,
  input  logic [DATA_WIDTH-1:0] D_data,
  output logic [DATA_WIDTH-1:0] registerA,
  output logic [DATA_WIDTH-1:0] registerB,
  output logic [ADDR_WIDTH-1:0] last_write_addr,
  output logic [7:0]            write_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [ADDR_WIDTH-1:0] last_write_addr_q, last_write_addr_d;
  logic [7:0]            write_count_q, write_count_d;
  logic                  dest_is_zero;
  logic                  write_commit;

  // A write to a hardwired R0 is discarded entirely, including its statistics.
  assign dest_is_zero = (DA == '0);
  assign write_commit = RW && !(ZERO_R0 && dest_is_zero);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (write_commit && (DA == ADDR_WIDTH'(i))) begin
        regs_d[i] = D_data;
      end
    end
    last_write_addr_d = last_write_addr_q;
    write_count_d     = write_count_q;
    if (write_commit) begin
      last_write_addr_d = DA;
      write_count_d     = write_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      last_write_addr_q <= '0;
      write_count_q     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      last_write_addr_q <= last_write_addr_d;
      write_count_q     <= write_count_d;
    end
  end

  // Bypass only applies to committed writes, so a hardwired R0 still reads 0.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] value;
    value = regs_q[addr];
    if (BYPASS && write_commit && (DA == addr)) begin
      value = D_data;
    end
    if (ZERO_R0 && (addr == '0)) begin
      value = '0;
    end
    return value;
  endfunction

  always_comb begin
    registerA = read_port(AA);
    registerB = read_port(BA);
  end

  assign last_write_addr = last_write_addr_q;
  assign write_count     = write_count_q;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a plain (BYPASS=0, ZERO_R0=0) and a bypass/zero-R0 instance
// share stimulus; an array model predicts every output each cycle, plus literal checks.
module tb_register_file;

  logic       clk;
  logic       reset;
  logic       RW;
  logic [2:0] DA, AA, BA;
  logic [7:0] D_data;
  logic [7:0] ra [2];
  logic [7:0] rb [2];
  logic [2:0] lwa [2];
  logic [7:0] wcnt [2];

  int total;
  int passed;

  register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut_plain (
    .clk(clk), .reset(reset), .RW(RW), .DA(DA), .AA(AA), .BA(BA), .D_data(D_data),
    .registerA(ra[0]), .registerB(rb[0]), .last_write_addr(lwa[0]), .write_count(wcnt[0])
  );

  register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut_bz (
    .clk(clk), .reset(reset), .RW(RW), .DA(DA), .AA(AA), .BA(BA), .D_data(D_data),
    .registerA(ra[1]), .registerB(rb[1]), .last_write_addr(lwa[1]), .write_count(wcnt[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: config 0 = plain, config 1 = bypass + hardwired R0.
  logic [7:0] m_mem [2][8];
  int         m_cnt [2];
  int         m_last [2];
  bit         model_valid = 1'b0;

  function automatic int unsigned exp_read(input int cfg, input logic [2:0] addr);
    bit special;
    special = (cfg == 1);
    if (special && addr == 3'd0) return 0;
    if (special && RW && DA != 3'd0 && DA == addr) return int'(D_data);
    return int'(m_mem[cfg][addr]);
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        for (int r = 0; r < 8; r++) m_mem[c][r] = 8'h00;
        m_cnt[c]  = 0;
        m_last[c] = 0;
      end else if (RW && !(c == 1 && DA == 3'd0)) begin
        m_mem[c][DA] = D_data;
        m_cnt[c]     = (m_cnt[c] + 1) % 256;
        m_last[c]    = int'(DA);
      end
    end
    if (reset) model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      for (int c = 0; c < 2; c++) begin
        check($sformatf("model_A[cfg%0d,AA=%0d]", c, AA), ra[c], exp_read(c, AA));
        check($sformatf("model_B[cfg%0d,BA=%0d]", c, BA), rb[c], exp_read(c, BA));
        check($sformatf("model_last[cfg%0d]", c), lwa[c], m_last[c]);
        check($sformatf("model_count[cfg%0d]", c), wcnt[c], m_cnt[c]);
      end
    end
  end

  task automatic drive(input logic rw, input logic [2:0] da, input logic [7:0] d,
                       input logic [2:0] aa, input logic [2:0] ba);
    RW = rw; DA = da; D_data = d; AA = aa; BA = ba;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    tick;
    tick;
    reset = 1'b0;

    // Reset clear, with a write presented during reset
    drive(1'b1, 3'd3, 8'hA5, 3'd3, 3'd3);
    tick;
    drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd3);
    settle;
    check("pre_reset_R3", ra[0], 32'hA5);
    tick;
    reset = 1'b1;
    drive(1'b1, 3'd3, 8'hFF, 3'd3, 3'd3);
    tick;
    reset = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd3);
    settle;
    check("reset_R3", ra[0], 32'h00);
    check("reset_count", wcnt[0], 0);
    check("reset_last", lwa[0], 0);
    tick;

    // Fill and readback
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'(8'h10 + i), 3'd0, 3'd0);
      tick;
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i));
      settle;
      check($sformatf("fill_A[%0d]", i), ra[0], 32'h10 + i);
      check($sformatf("fill_B[%0d]", 7 - i), rb[0], 32'h17 - i);
      tick;
    end
    settle;
    check("fill_count", wcnt[0], 8);
    check("fill_last", lwa[0], 7);
    check("fill_count_zr0", wcnt[1], 7);
    tick;

    // Same-cycle read/write of R5
    drive(1'b1, 3'd5, 8'h3C, 3'd0, 3'd0);
    tick;
    drive(1'b1, 3'd5, 8'hC3, 3'd5, 3'd5);
    settle;
    check("rw_same_A_nobyp", ra[0], 32'h3C);
    check("rw_same_B_nobyp", rb[0], 32'h3C);
    check("rw_same_A_byp", ra[1], 32'hC3);
    check("rw_same_B_byp", rb[1], 32'hC3);
    tick;
    drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd5);
    settle;
    check("rw_after_A_nobyp", ra[0], 32'hC3);
    tick;

    // Hardwired R0
    drive(1'b1, 3'd0, 8'h77, 3'd0, 3'd0);
    settle;
    check("r0_before_zr0", ra[1], 32'h00);
    tick;
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    settle;
    check("r0_after_zr0", ra[1], 32'h00);
    check("r0_count_zr0", wcnt[1], 9);
    check("r0_last_zr0", lwa[1], 5);
    check("r0_after_plain", ra[0], 32'h77);
    check("r0_count_plain", wcnt[0], 11);
    tick;

    // RW low holds state
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'd2, 8'h99, 3'd2, 3'd2);
      tick;
    end
    settle;
    check("rwlow_R2", ra[0], 32'h12);
    check("rwlow_count", wcnt[0], 11);
    tick;

    // Counter wrap after a fresh reset
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 3'd1, 8'(i), 3'd1, 3'd2);
      tick;
    end
    drive(1'b0, 3'd0, 8'h00, 3'd1, 3'd1);
    settle;
    check("wrap_count", wcnt[0], 0);
    check("wrap_R1", ra[0], 32'hFF);
    check("wrap_last", lwa[0], 1);
    check("wrap_count_zr0", wcnt[1], 0);
    tick;

    // Randomized traffic, occasional reset
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom),
            3'($urandom), 3'($urandom));
      tick;
    end
    reset = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    settle;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
